// File: rtl/spi_master_pkg.sv
// Shared types for the SPI master engine.
// Build option: SPI_MASTER_LOOPBACK_EN adds an internal MOSI->sampler loop.
package spi_master_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      LEAD,
      TRAIL,
      GAP
   } state_e;

   // Wide enough for any SS_WIDTH up to 32; users slice the low bits.
   localparam logic [31:0] SS_NONE = '1;

endpackage

// File: rtl/spi_master_if.sv
// Word stream between the register/FIFO front end and the SPI engine.
// master: front end side; slave: engine side.
interface spi_master_if #(
   parameter int DATA_W = 8
);

   logic              tx_valid_i;
   logic              tx_ready_o;
   logic [DATA_W-1:0] tx_data_i;
   logic              rx_valid_o;
   logic [DATA_W-1:0] rx_data_o;

   modport master (
      output tx_valid_i,
      output tx_data_i,
      input  tx_ready_o,
      input  rx_valid_o,
      input  rx_data_o
   );

   modport slave (
      input  tx_valid_i,
      input  tx_data_i,
      output tx_ready_o,
      output rx_valid_o,
      output rx_data_o
   );

endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator; reloads with div_i+1 on every restart.
module spi_clk_div #(
   parameter int DIV_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             restart_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             tick_o
);

   localparam int CW = DIV_W + 1;

   // One extra bit so div_i = all-ones loads 2^DIV_W without wrapping.
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= '0;
      else if (restart_i)
         cnt_q <= {1'b0, div_i} + CW'(1);
      else if (cnt_q != '0)
         cnt_q <= cnt_q - CW'(1);
   end

   assign tick_o = (cnt_q == CW'(1));

endmodule

// File: rtl/spi_master_core.sv
// Parametrised SPI master engine, all four CPOL/CPHA modes.
// Build option: SPI_MASTER_LOOPBACK_EN adds loop_i (sampler reads mosi_o).
module spi_master_core
   import spi_master_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int SS_WIDTH  = 1,
   parameter int DIV_W     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                en_i,
   input  logic                cpol_i,
   input  logic                cpha_i,
   input  logic [DIV_W-1:0]    div_i,
   input  logic [SS_WIDTH-1:0] ss_sel_i,
   input  logic                ss_hold_i,
`ifdef SPI_MASTER_LOOPBACK_EN
   input  logic                loop_i,
`endif
   spi_master_if.slave         bus,
   output logic                busy_o,
   output logic                sck_o,
   output logic                mosi_o,
   input  logic                miso_i,
   output logic [SS_WIDTH-1:0] ss_n_o
);

   localparam int BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [SS_WIDTH-1:0] SS_OFF = SS_NONE[SS_WIDTH-1:0];

   state_e              state_q, state_n;
   logic [DATA_W-1:0]   sh_q, rx_sh_q;
   logic [DATA_W-1:0]   sh_src, shl;
   logic [BW-1:0]       bit_q;
   logic [DIV_W-1:0]    div_q, div_c;
   logic                cpol_q, cpha_q, hold_q;
   logic                cpol_c, fb, sbit;
   logic                accept, abort, tick;
   logic                enter_lead, enter_trail, to_gap, gap_exit;
   logic                next_bit, do_drive, sample;

   assign bus.tx_ready_o = (state_q == IDLE) && en_i && !rst_i;
   assign accept         = bus.tx_valid_i && bus.tx_ready_o;
   assign busy_o         = (state_q != IDLE);
   assign abort          = !en_i && (state_q != IDLE);

   always_comb begin
      state_n = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_n = SETUP;
         SETUP:   if (tick)   state_n = LEAD;
         LEAD:    if (tick)   state_n = TRAIL;
         TRAIL:   if (tick)   state_n = (bit_q == '0) ? GAP : LEAD;
         GAP:     if (tick)   state_n = IDLE;
         default:             state_n = IDLE;
      endcase
      if (abort) state_n = IDLE;
   end

   assign enter_lead  = (state_n == LEAD)  && (state_q != LEAD);
   assign enter_trail = (state_n == TRAIL) && (state_q == LEAD);
   assign to_gap      = (state_n == GAP)   && (state_q == TRAIL);
   assign gap_exit    = (state_n == IDLE)  && (state_q == GAP);
   assign next_bit    = (state_n == LEAD)  && (state_q == TRAIL);

   // Idle level follows the live input; a transfer uses the latched copy.
   assign cpol_c = (state_q == IDLE) ? cpol_i : cpol_q;
   assign div_c  = (state_q == IDLE) ? div_i  : div_q;

   spi_clk_div #(.DIV_W(DIV_W)) u_div (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .restart_i (state_n != state_q),
      .div_i     (div_c),
      .tick_o    (tick)
   );

   // CPHA=0 presents the first bit at accept, later bits at trailing edges.
   assign do_drive = accept ? !cpha_i : (cpha_q ? enter_lead : enter_trail);
   assign sample   = cpha_q ? enter_trail : enter_lead;
   assign sh_src   = accept ? bus.tx_data_i : sh_q;
   assign fb       = MSB_FIRST ? sh_src[DATA_W-1] : sh_src[0];
   assign shl      = MSB_FIRST ? {sh_src[DATA_W-2:0], 1'b0}
                               : {1'b0, sh_src[DATA_W-1:1]};

`ifdef SPI_MASTER_LOOPBACK_EN
   logic loop_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)       loop_q <= 1'b0;
      else if (accept) loop_q <= loop_i;
   end

   assign sbit = loop_q ? mosi_o : miso_i;
`else
   assign sbit = miso_i;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= IDLE;
         sh_q           <= '0;
         rx_sh_q        <= '0;
         bit_q          <= '0;
         div_q          <= '0;
         cpol_q         <= 1'b0;
         cpha_q         <= 1'b0;
         hold_q         <= 1'b0;
         sck_o          <= 1'b0;
         mosi_o         <= 1'b0;
         ss_n_o         <= SS_OFF;
         bus.rx_valid_o <= 1'b0;
         bus.rx_data_o  <= '0;
      end else begin
         state_q        <= state_n;
         sck_o          <= (state_n == LEAD) ? ~cpol_c : cpol_c;
         bus.rx_valid_o <= to_gap;
         if (to_gap)
            bus.rx_data_o <= rx_sh_q;

         if (accept) begin
            sh_q   <= bus.tx_data_i;
            bit_q  <= BW'(DATA_W - 1);
            div_q  <= div_i;
            cpol_q <= cpol_i;
            cpha_q <= cpha_i;
            hold_q <= ss_hold_i;
            ss_n_o <= ~ss_sel_i;
         end else if (abort) begin
            hold_q <= 1'b0;
            ss_n_o <= SS_OFF;
         end else if (gap_exit && !hold_q) begin
            ss_n_o <= SS_OFF;
         end

         if (next_bit)
            bit_q <= bit_q - BW'(1);

         if (do_drive) begin
            mosi_o <= fb;
            sh_q   <= shl;
         end

         if (sample)
            rx_sh_q <= MSB_FIRST ? {rx_sh_q[DATA_W-2:0], sbit}
                                 : {sbit, rx_sh_q[DATA_W-1:1]};
      end
   end

endmodule
